// File: rtl/lbp_code_reader.sv
// LBP code reader: collects comparator decisions into NBITS-wide codes, queues them
// with a sequence tag in a small FIFO, and exposes them over a Wishbone classic slave.
module lbp_code_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
  parameter int          NBITS     = 12,
  parameter int          DEPTH     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmp_i,
  input  logic        frame_start_i,
  input  logic        sample_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, PUSH = 2'd2} state_t;
  typedef struct packed {
    logic [7:0]       seq;
    logic [NBITS-1:0] code;
  } entry_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [NBITS-1:0] shreg;
  logic [7:0]       seq;
  logic [1:0]       cmp_sync, smp_pipe, fs_pipe;
  logic             cmp_s, smp_d, fs_d;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             empty, full;

  logic             ctrl_en, ctrl_irq, ovf, short_f;
  logic             hit, accept, rd, wr, pop, push_ev, push_ok, flush;
  logic             ctrl_wr, flags_wr, ovf_set, short_set;
  logic [1:0]       reg_sel;
  logic [31:0]      rdata;
  entry_t           head;
  logic             unused_ok;

  assign cmp_s = cmp_sync[1];
  assign smp_d = smp_pipe[1];
  assign fs_d  = fs_pipe[1];

  // cmp_i is asynchronous; sample/frame pulses ride the same 2-stage delay so they line up
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmp_sync <= '0;
      smp_pipe <= '0;
      fs_pipe  <= '0;
    end else begin
      cmp_sync <= {cmp_sync[0], cmp_i};
      smp_pipe <= {smp_pipe[0], sample_i};
      fs_pipe  <= {fs_pipe[0], frame_start_i};
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept   = hit & ~wbs_ack_o;
  assign reg_sel  = wbs_adr_i[3:2];
  assign rd       = accept & ~wbs_we_i;
  assign wr       = accept & wbs_we_i;
  assign pop      = rd & (reg_sel == 2'd0) & ~empty;
  assign ctrl_wr  = wr & (reg_sel == 2'd2) & wbs_sel_i[0];
  assign flags_wr = wr & (reg_sel == 2'd3) & wbs_sel_i[0];
  assign flush    = ctrl_wr & wbs_dat_i[2];

  // A simultaneous pop frees a slot, so a full FIFO still accepts the push
  assign push_ev   = (state == PUSH);
  assign push_ok   = push_ev & (~full | pop) & ~flush;
  assign ovf_set   = push_ev & full & ~pop & ~flush;
  assign short_set = (state == COLLECT) & ctrl_en & fs_d & (idx != '0);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      idx   <= '0;
      shreg <= '0;
      seq   <= '0;
    end else begin
      if (flush)        seq <= '0;
      else if (push_ev) seq <= seq + 8'd1;
      case (state)
        IDLE: if (ctrl_en && fs_d) begin
          state <= COLLECT;
          idx   <= '0;
          shreg <= '0;
        end
        COLLECT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (fs_d) begin
            idx   <= '0;
            shreg <= '0;
          end else if (smp_d) begin
            // LSB-first: after NBITS shifts the first decision sits at bit 0
            shreg <= (shreg >> 1) | (NBITS'(cmp_s) << (NBITS - 1));
            if (idx == IW'(NBITS - 1)) state <= PUSH;
            else                       idx   <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= '{seq: seq, code: shreg};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: if (!empty) begin
        rdata[31]          = 1'b1;
        rdata[23:16]       = head.seq;
        rdata[NBITS-1:0]   = head.code;
      end
      2'd1: begin
        rdata[3:0] = 4'(count);
        rdata[4]   = empty;
        rdata[5]   = full;
        rdata[6]   = ovf;
        rdata[7]   = short_f;
        rdata[9:8] = state;
      end
      2'd2:    rdata[1:0] = {ctrl_irq, ctrl_en};
      default: rdata[7:6] = {short_f, ovf};
    endcase
  end

  // New events win over a same-cycle W1C so none is lost
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_en   <= 1'b0;
      ctrl_irq  <= 1'b0;
      ovf       <= 1'b0;
      short_f   <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= rd ? rdata : '0;
      if (ctrl_wr) begin
        ctrl_en  <= wbs_dat_i[0];
        ctrl_irq <= wbs_dat_i[1];
      end
      if (ovf_set)                        ovf <= 1'b1;
      else if (flags_wr && wbs_dat_i[6])  ovf <= 1'b0;
      if (short_set)                      short_f <= 1'b1;
      else if (flags_wr && wbs_dat_i[7])  short_f <= 1'b0;
    end
  end

  assign irq_o = ctrl_irq & ~empty;

  assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_dat_i[5:3], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_lbp_code_reader.sv
// Randomized bench for lbp_code_reader: frames are driven at the sequencer level and
// checked against a queue-based model of the code FIFO, sequence tag and sticky flags.
module tb_lbp_code_reader;
  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmp_i = 1'b0, frame_start_i = 1'b0, sample_i = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        irq_o;

  int total = 0, bad = 0;
  logic [31:0] mq[$];
  int  mseq = 0;
  bit  movf = 0, mshort = 0;

  lbp_code_reader dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cmp_i(cmp_i),
    .frame_start_i(frame_start_i), .sample_i(sample_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mword(input logic [11:0] code);
    logic [31:0] w;
    w = '0; w[31] = 1'b1; w[23:16] = mseq[7:0]; w[11:0] = code;
    return w;
  endfunction

  function automatic void model_push(input logic [11:0] code);
    if (mq.size() < 8) mq.push_back(mword(code));
    else movf = 1;
    mseq = (mseq + 1) % 256;
  endfunction

  function automatic void model_flush();
    mq.delete(); mseq = 0;
  endfunction

  function automatic logic [31:0] mstatus();
    logic [31:0] s;
    s = '0; s[3:0] = 4'(mq.size()); s[4] = (mq.size() == 0); s[5] = (mq.size() == 8);
    s[6] = movf; s[7] = mshort;
    return s;
  endfunction

  // ---------------- bus / sequencer drivers ----------------
  task automatic wb_read(input logic [3:0] off, output logic [31:0] d);
    bit ok = 0;
    d = '0;
    wbs_adr_i = BASE | {28'h0, off}; wbs_we_i = 0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin ok = 1; d = wbs_dat_o; end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    if (!ok) begin total++; bad++; $display("FAIL wb_read_ack off=%h got=0 want=1", off); end
    @(negedge wb_clk_i);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    bit ok = 0;
    wbs_adr_i = BASE | {28'h0, off}; wbs_we_i = 1; wbs_dat_i = d; wbs_sel_i = sel;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    for (int n = 0; n < 8 && !ok; n++) begin
      @(posedge wb_clk_i); #1;
      ok = wbs_ack_o;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    if (!ok) begin total++; bad++; $display("FAIL wb_write_ack off=%h got=0 want=1", off); end
    @(negedge wb_clk_i);
  endtask

  // Leaves the final sample pulse asserted so callers can align a bus access with PUSH
  task automatic frame_bits(input logic [11:0] code, input int nb, input bit with_fs);
    if (with_fs) begin
      frame_start_i = 1; @(negedge wb_clk_i); frame_start_i = 0;
    end
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
      cmp_i = code[i]; sample_i = 1;
      if (i != nb - 1) begin @(negedge wb_clk_i); sample_i = 0; end
    end
  endtask

  task automatic end_frame();
    @(negedge wb_clk_i); sample_i = 0; cmp_i = 0;
    repeat (5) @(negedge wb_clk_i);
  endtask

  task automatic full_frame(input logic [11:0] code);
    frame_bits(code, 12, 1); end_frame(); model_push(code);
  endtask

  // Read DATA on exactly the edge at which the last frame's PUSH lands
  task automatic frame_with_aligned_read(input logic [11:0] code, output logic [31:0] d);
    frame_bits(code, 12, 1);
    @(negedge wb_clk_i); sample_i = 0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_read(4'h0, d);
    repeat (3) @(negedge wb_clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge wb_clk_i);
    total++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || irq_o !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got ack=%b dat=%h irq=%b want 0", wbs_ack_o, wbs_dat_o, irq_o);
    end
    wb_rst_i = 0; @(negedge wb_clk_i);
    wb_read(4'h4, d);
    total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL reset_status got=%h want=00000010", d); end
    wb_read(4'h8, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d, e;
    logic [11:0] c;
    wb_write(4'h8, 32'h1, 4'hF);
    full_frame(12'h80D);
    wb_read(4'h0, d); e = mq.pop_front();
    total++; if (d !== 32'h8000_080D) begin bad++; $display("FAIL basic_pattern got=%h want=8000080d", d); end
    c = 12'($urandom);
    full_frame(c);
    wb_read(4'h0, d); e = mq.pop_front();
    total++; if (d !== e || d[23:16] !== 8'h01) begin bad++; $display("FAIL basic_seq1 got=%h want=%h", d, e); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    wb_write(4'h8, 32'h5, 4'hF); model_flush();
    for (int i = 0; i < 9; i++) full_frame(12'($urandom));
    wb_read(4'h4, d);
    total++; if (d !== mstatus() || d[3:0] !== 4'd8 || d[6:5] !== 2'b11) begin
      bad++; $display("FAIL ovf_status got=%h want=%h", d, mstatus());
    end
    for (int i = 0; i < 9; i++) begin
      e = (mq.size() != 0) ? mq.pop_front() : 32'h0;
      wb_read(4'h0, d);
      total++; if (d !== e) begin bad++; $display("FAIL ovf_read%0d got=%h want=%h", i, d, e); end
    end
  endtask

  task automatic test_short();
    logic [31:0] d;
    wb_write(4'h8, 32'h5, 4'hF); model_flush();
    frame_bits(12'($urandom), 5, 1); end_frame(); mshort = 1;
    full_frame(12'hFFF);
    wb_read(4'h4, d);
    total++; if (d !== mstatus() || d[7] !== 1'b1) begin bad++; $display("FAIL short_status got=%h want=%h", d, mstatus()); end
    wb_read(4'h0, d); void'(mq.pop_front());
    total++; if (d !== 32'h8000_0FFF) begin bad++; $display("FAIL short_data got=%h want=80000fff", d); end
  endtask

  task automatic test_flags();
    logic [31:0] d, e;
    wb_write(4'h8, 32'h3, 4'hF);
    full_frame(12'($urandom)); full_frame(12'($urandom));
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_on got=%b want=1", irq_o); end
    wb_read(4'hC, d);
    total++; if (d !== {24'h0, mshort, movf, 6'h0}) begin bad++; $display("FAIL flags_read got=%h want=%h", d, {24'h0, mshort, movf, 6'h0}); end
    wb_write(4'hC, 32'hC0, 4'hF); movf = 0; mshort = 0;
    wb_read(4'h4, d);
    total++; if (d !== mstatus()) begin bad++; $display("FAIL flags_clear got=%h want=%h", d, mstatus()); end
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_after_clear got=%b want=1", irq_o); end
    for (int i = 0; i < 2; i++) begin
      e = mq.pop_front(); wb_read(4'h0, d);
      total++; if (d !== e) begin bad++; $display("FAIL flags_drain got=%h want=%h", d, e); end
    end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_off got=%b want=0", irq_o); end
  endtask

  task automatic test_pop_push();
    logic [31:0] d, e;
    logic [11:0] c;
    wb_write(4'h8, 32'h5, 4'hF); model_flush();
    c = 12'($urandom);
    frame_with_aligned_read(c, d); model_push(c);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL popempty_read got=%h want=0", d); end
    wb_read(4'h4, d);
    total++; if (d !== mstatus()) begin bad++; $display("FAIL popempty_status got=%h want=%h", d, mstatus()); end
    for (int i = 0; i < 7; i++) full_frame(12'($urandom));
    c = 12'($urandom);
    frame_with_aligned_read(c, d); e = mq.pop_front(); model_push(c);
    total++; if (d !== e) begin bad++; $display("FAIL popfull_read got=%h want=%h", d, e); end
    wb_read(4'h4, d);
    total++; if (d !== mstatus() || d[3:0] !== 4'd8 || d[6] !== 1'b0) begin
      bad++; $display("FAIL popfull_status got=%h want=%h", d, mstatus());
    end
    for (int i = 0; i < 8; i++) begin
      e = mq.pop_front(); wb_read(4'h0, d);
      total++; if (d !== e) begin bad++; $display("FAIL popfull_drain%0d got=%h want=%h", i, d, e); end
    end
  endtask

  task automatic test_en_clear();
    logic [31:0] d, e;
    logic [11:0] c;
    c = 12'($urandom);
    frame_bits(c, 4, 1); end_frame();
    wb_read(4'h4, d);
    total++; if (d !== (mstatus() | 32'h100)) begin bad++; $display("FAIL en_collect_state got=%h want=%h", d, mstatus() | 32'h100); end
    wb_write(4'h8, 32'h0, 4'hF);
    frame_bits(c, 8, 0); end_frame();
    wb_write(4'h8, 32'h1, 4'hF);
    wb_read(4'h4, d);
    total++; if (d !== mstatus()) begin bad++; $display("FAIL en_clear_status got=%h want=%h", d, mstatus()); end
    full_frame(12'($urandom));
    e = mq.pop_front(); wb_read(4'h0, d);
    total++; if (d !== e) begin bad++; $display("FAIL en_clear_next got=%h want=%h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    full_frame(12'($urandom)); full_frame(12'($urandom));
    frame_bits(12'($urandom), 5, 1); end_frame();
    wb_rst_i = 1; repeat (2) @(negedge wb_clk_i); wb_rst_i = 0; @(negedge wb_clk_i);
    model_flush(); movf = 0; mshort = 0;
    wb_read(4'h4, d);
    total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL rstmid_status got=%h want=00000010", d); end
    wb_write(4'h8, 32'h1, 4'hF);
    full_frame(12'($urandom));
    e = mq.pop_front(); wb_read(4'h0, d);
    total++; if (d !== e || d[23:16] !== 8'h00) begin bad++; $display("FAIL rstmid_seq got=%h want=%h", d, e); end
  endtask

  task automatic test_ack();
    logic [31:0] d;
    logic a1, a2;
    bit seen = 0;
    wbs_adr_i = BASE + 32'h10; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
    for (int n = 0; n < 4; n++) begin @(posedge wb_clk_i); #1; if (wbs_ack_o) seen = 1; end
    wbs_cyc_i = 0; wbs_stb_i = 0; @(negedge wb_clk_i);
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ack_mismatch got=1 want=0"); end
    wbs_adr_i = BASE | 32'h4; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(posedge wb_clk_i); #1; a1 = wbs_ack_o;
    @(posedge wb_clk_i); #1; a2 = wbs_ack_o;
    wbs_cyc_i = 0; wbs_stb_i = 0; @(negedge wb_clk_i);
    total++; if ({a1, a2} !== 2'b10) begin bad++; $display("FAIL ack_single got=%b%b want=10", a1, a2); end
    wb_write(4'h8, 32'h2, 4'b1110);
    wb_read(4'h8, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL sel_lanes got=%h want=00000001", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_short();
    test_flags();
    test_pop_push();
    test_en_clear();
    test_reset_mid();
    test_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lbp_code_reader.md
LBP_CODE_READER -- requirements
Module: lbp_code_reader

Interface
REQ-001 Parameter: BASE_ADDR, 32'h3000_0100, Wishbone base; decode wbs_adr_i[31:4]==BASE_ADDR[31:4].
REQ-002 Parameter: NBITS, 12, comparator decisions per LBP code (one per photodiode pair); legal range 1..16.
REQ-003 Parameter: DEPTH, 8, code FIFO depth; power of two.
REQ-004 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 cmp_i  in  1  comparator output from the analog macro, asynchronous to wb_clk_i.
REQ-007 frame_start_i  in  1  one-cycle pulse from the sequencer at the start of each code frame.
REQ-008 sample_i  in  1  one-cycle pulse from the sequencer when the comparator decision for the current bit is settled.
REQ-009 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
REQ-010 wbs_sel_i  in  4; wbs_adr_i  in  32; wbs_dat_i  in  32  Wishbone request.
REQ-011 wbs_ack_o  out  1; wbs_dat_o  out  32  Wishbone response.
REQ-012 irq_o  out  1  level interrupt, high while FIFO non-empty and CTRL.irq_en=1.

Function
REQ-013 cmp_i SHALL pass through a 2-FF synchronizer; sample_i and frame_start_i SHALL be delayed 2 cycles to match, so each decision is taken from the synchronized cmp_i at the delayed sample_i.
REQ-014 FSM states: IDLE, COLLECT, PUSH; leaving IDLE requires CTRL.en=1.
REQ-015 IDLE -> COLLECT on delayed frame_start; bit index cleared to 0, shift register cleared.
REQ-016 COLLECT: each delayed sample writes bit[index], LSB first, and increments index; at index NBITS-1 -> PUSH.
REQ-017 PUSH (exactly one cycle): word {seq[7:0], code[NBITS-1:0]} is written to the FIFO, seq increments mod 256, and the FSM goes to IDLE.
REQ-018 Delayed frame_start in COLLECT with index!=0: partial code discarded, STATUS.short set (sticky), restart COLLECT at index 0.
REQ-019 Delayed sample in IDLE: ignored, no flag.
REQ-020 PUSH with FIFO full: word dropped, seq still increments, STATUS.ovf set (sticky).
REQ-021 CTRL.en cleared mid-frame: FSM to IDLE the next cycle and the partial code is discarded; FIFO contents are kept.
REQ-022 Registers (offset = wbs_adr_i[3:2]): 0x0 DATA (RO, read pops), 0x4 STATUS (RO), 0x8 CTRL (RW), 0xC FLAGS (W1C).
REQ-023 DATA read format: [31] valid, [23:16] seq, [NBITS-1:0] code, other bits 0; when empty, reads 0 and does not pop.
REQ-024 STATUS format: [3:0] count (0..DEPTH), [4] empty, [5] full, [6] ovf, [7] short, [9:8] FSM state (IDLE=0, COLLECT=1, PUSH=2).
REQ-025 CTRL format: [0] en, [1] irq_en, [2] flush (self-clearing; empties FIFO and zeroes seq).
REQ-026 FLAGS: writing 1 to [6] clears ovf and writing 1 to [7] clears short; reads return the STATUS[7:6] positions.
REQ-027 Ack: wbs_ack_o pulses high exactly one cycle after the first cycle of cyc&stb with matching address; it SHALL NOT re-ack while stb is held in that cycle; no ack on address mismatch.
REQ-028 wbs_dat_o is valid in the ack cycle and 0 otherwise; a write honours wbs_sel_i byte lanes.
REQ-029 Pop (DATA read ack) and PUSH in the same cycle: both take effect and count is unchanged; if the FIFO was full, the push succeeds and ovf is not set.
REQ-030 Pop and PUSH on an empty FIFO in the same cycle: the read returns 0 and the pushed word remains.
REQ-031 Pointers wrap modulo DEPTH; count saturates at neither bound beyond 0..DEPTH.

Reset
REQ-032 On wb_rst_i=1 at a clock edge, all of the following SHALL be cleared: FSM=IDLE, index=0, seq=0, FIFO empty, ovf=short=0, CTRL=0, synchronizers=0, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
REQ-033 Reset asserted mid-transaction SHALL suppress a pending ack.

Verification
REQ-034 en=1; frame_start, then 12 samples with cmp pattern 1,0,1,1,0,0,0,0,0,0,0,1 -> DATA read = 0x8000_080D; next frame gives seq=0x01.
REQ-035 9 complete frames with no reads -> STATUS count=8, full=1, ovf=1; the first 8 DATA reads return seq 0..7, and the 9th read returns 0.
REQ-036 frame_start after 5 samples, then 12 samples of all ones -> short=1, DATA code=0xFFF, seq=0x00.
REQ-037 FIFO full, DATA read in the same cycle as PUSH -> count stays 8, ovf=0.
REQ-038 wb_rst_i pulsed during COLLECT with 2 words queued -> STATUS reads 0x0000_0010; the next complete frame is stored with seq=0.
REQ-039 Write FLAGS=0xC0 with ovf and short set -> both clear; irq_o follows (count!=0 & irq_en).
